vx_avs_ram_slave: RTL and testbench

- Single-bank Avalon-MM slave backed by on-chip RAM; sits directly downstream of one bank of the AVS adapter's avs_* master bus.
- Serves single-beat and burst reads/writes with byte enables, fixed read latency and waitrequest flow control.
- Used as the local-memory target in FPGA builds and as the memory model in simulation.

---
 rtl/vx_avs_pkg.sv | 15 +
 rtl/vx_avs_rd_pipe.sv | 64 ++++++
 rtl/vx_avs_ram_slave.sv | 144 ++++++++++++++
 tb/tb_vx_avs_ram_slave.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_avs_pkg.sv
// Shared types and helpers for the AVS RAM slave and its read pipe.
package vx_avs_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } avs_ram_state_e;

    // A burstcount of zero is a single-beat transfer.
    function automatic int unsigned burst_beats(input int unsigned burstcount);
        return (burstcount == 0) ? 1 : burstcount;
    endfunction

endpackage

// File: rtl/vx_avs_rd_pipe.sv
// Fixed-latency valid/data shift pipe between the RAM read port and avs_readdata.
// Internal data stages are not reset; the output stage holds its value between beats.
module vx_avs_rd_pipe #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  tail_valid;
    logic [DATA_WIDTH-1:0] tail_data;

    if (LATENCY == 1) begin : g_direct
        assign tail_valid = in_valid;
        assign tail_data  = in_data;
    end else begin : g_shift
        logic [LATENCY-2:0]    valid_q;
        logic [DATA_WIDTH-1:0] data_q [LATENCY-1];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                valid_q <= '0;
            end else begin
                valid_q[0] <= in_valid;
                for (int unsigned i = 1; i < LATENCY - 1; i++) begin
                    valid_q[i] <= valid_q[i-1];
                end
            end
        end

        // Data stages only move with a valid beat to avoid needless toggling.
        always_ff @(posedge clk) begin
            if (in_valid) begin
                data_q[0] <= in_data;
            end
            for (int unsigned i = 1; i < LATENCY - 1; i++) begin
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end

        assign tail_valid = valid_q[LATENCY-2];
        assign tail_data  = data_q[LATENCY-2];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= tail_valid;
            if (tail_valid) begin
                out_data <= tail_data;
            end
        end
    end

endmodule

// File: rtl/vx_avs_ram_slave.sv
// Single-bank Avalon-MM slave over on-chip RAM: burst reads/writes, byte enables,
// fixed read latency, waitrequest held only while a read burst is being issued.
module vx_avs_ram_slave
    import vx_avs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned BURST_WIDTH  = 4,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   avs_address,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [DATA_WIDTH-1:0]   avs_writedata,
    input  logic [DATA_WIDTH/8-1:0] avs_byteenable,
    input  logic [BURST_WIDTH-1:0]  avs_burstcount,
    output logic                    avs_waitrequest,
    output logic [DATA_WIDTH-1:0]   avs_readdata,
    output logic                    avs_readdatavalid
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    avs_ram_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0]   next_addr_q, next_addr_d;
    logic [BURST_WIDTH-1:0]  remaining_q, remaining_d;
    logic                    wr_en, rd_en;
    logic [ADDR_WIDTH-1:0]   wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0]   rd_data;
    int unsigned             beats;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign beats = burst_beats(32'(avs_burstcount));

    // Next-state, beat issue and burst bookkeeping.
    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        remaining_d = remaining_q;
        wr_en       = 1'b0;
        wr_addr     = avs_address;
        rd_en       = 1'b0;
        rd_addr     = avs_address;
        unique case (state_q)
            IDLE: begin
                if (!avs_waitrequest) begin
                    // Write wins over a simultaneous read; the read is dropped.
                    if (avs_write) begin
                        wr_en = 1'b1;
                        if (beats > 1) begin
                            next_addr_d = avs_address + ADDR_WIDTH'(1);
                            remaining_d = BURST_WIDTH'(beats - 1);
                            state_d     = WR_BURST;
                        end
                    end else if (avs_read) begin
                        rd_en = 1'b1;
                        if (beats > 1) begin
                            next_addr_d = avs_address + ADDR_WIDTH'(1);
                            remaining_d = BURST_WIDTH'(beats - 1);
                            state_d     = RD_BURST;
                        end
                    end
                end
            end
            RD_BURST: begin
                rd_en       = 1'b1;
                rd_addr     = next_addr_q;
                next_addr_d = next_addr_q + ADDR_WIDTH'(1);
                remaining_d = remaining_q - BURST_WIDTH'(1);
                if (remaining_q == BURST_WIDTH'(1)) begin
                    state_d = IDLE;
                end
            end
            WR_BURST: begin
                if (avs_write) begin
                    wr_en       = 1'b1;
                    wr_addr     = next_addr_q;
                    next_addr_d = next_addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - BURST_WIDTH'(1);
                    if (remaining_q == BURST_WIDTH'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            next_addr_q     <= '0;
            remaining_q     <= '0;
            avs_waitrequest <= 1'b1;
        end else begin
            state_q         <= state_d;
            next_addr_q     <= next_addr_d;
            remaining_q     <= remaining_d;
            avs_waitrequest <= (state_d == RD_BURST);
        end
    end

    // Byte-enable RAM; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (avs_byteenable[b]) begin
                    mem[wr_addr][8*b +: 8] <= avs_writedata[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = mem[rd_addr];

    vx_avs_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_en),
        .in_data   (rd_data),
        .out_valid (avs_readdatavalid),
        .out_data  (avs_readdata)
    );

    // Master protocol checks.
    always @(posedge clk) begin
        if (state_q == IDLE && !avs_waitrequest) begin
            assert (!(avs_read && avs_write))
                else $warning("avs protocol: read and write together, read dropped");
        end
        if (state_q == WR_BURST) begin
            assert (!avs_read)
                else $warning("avs protocol: read during write burst ignored");
        end
    end

endmodule

// File: tb/tb_vx_avs_ram_slave.sv
// Randomized bench for vx_avs_ram_slave against a transaction-level memory model.
module tb_vx_avs_ram_slave;

    localparam int unsigned DW    = 512;
    localparam int unsigned AW    = 10;
    localparam int unsigned BW    = 4;
    localparam int unsigned RL    = 2;
    localparam int unsigned NB    = DW / 8;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] avs_address = '0;
    logic          avs_read = 1'b0;
    logic          avs_write = 1'b0;
    logic [DW-1:0] avs_writedata = '0;
    logic [NB-1:0] avs_byteenable = '0;
    logic [BW-1:0] avs_burstcount = '0;
    logic          avs_waitrequest;
    logic [DW-1:0] avs_readdata;
    logic          avs_readdatavalid;

    vx_avs_ram_slave #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .reset(reset),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_burstcount(avs_burstcount), .avs_waitrequest(avs_waitrequest),
        .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: memory image plus a queue of (due cycle, data) read returns.
    typedef struct {
        int unsigned   due;
        logic [DW-1:0] data;
    } rd_exp_t;

    logic [DW-1:0] mdl_mem [DEPTH];
    rd_exp_t       exp_q[$];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_data = '0;
    int unsigned   cyc = 0;
    int unsigned   vcount = 0;
    int unsigned   rd_left = 0;
    int unsigned   wr_left = 0;
    logic [AW-1:0] m_addr = '0;
    bit            rst_pending;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) rst_pending <= 1'b1;
        else        rst_pending <= 1'b0;
    end

    function automatic void mdl_write(input logic [AW-1:0] a);
        for (int b = 0; b < int'(NB); b++)
            if (avs_byteenable[b]) mdl_mem[a][8*b +: 8] = avs_writedata[8*b +: 8];
    endfunction

    function automatic int unsigned beats_of(input logic [BW-1:0] bc);
        return (bc == 0) ? 1 : int'(bc);
    endfunction

    // Compare process: outputs of this cycle first, then account for this cycle's inputs.
    always @(negedge clk) begin
        bit e_wait;
        bit e_valid;
        if (!reset) begin
            exp_q.delete();
            rd_left  = 0;
            wr_left  = 0;
            exp_data = '0;
            check("reset_waitrequest", DW'(avs_waitrequest), DW'(1));
            check("reset_readdatavalid", DW'(avs_readdatavalid), DW'(0));
            check("reset_readdata", avs_readdata, exp_data);
        end else begin
            e_wait  = rst_pending || (rd_left > 0);
            e_valid = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            if (e_valid) begin
                exp_data = exp_q[0].data;
                void'(exp_q.pop_front());
            end
            check("waitrequest", DW'(avs_waitrequest), DW'(e_wait));
            check("readdatavalid", DW'(avs_readdatavalid), DW'(e_valid));
            check("readdata", avs_readdata, exp_data);
            if (avs_readdatavalid) begin
                vcount++;
                got_q.push_back(avs_readdata);
            end
            if (rd_left > 0) begin
                exp_q.push_back('{cyc + RL, mdl_mem[m_addr]});
                m_addr++;
                rd_left--;
            end else if (!e_wait) begin
                if (wr_left > 0) begin
                    if (avs_write) begin
                        mdl_write(m_addr);
                        m_addr++;
                        wr_left--;
                    end
                end else if (avs_write) begin
                    mdl_write(avs_address);
                    wr_left = beats_of(avs_burstcount) - 1;
                    m_addr  = avs_address + AW'(1);
                end else if (avs_read) begin
                    exp_q.push_back('{cyc + RL, mdl_mem[avs_address]});
                    rd_left = beats_of(avs_burstcount) - 1;
                    m_addr  = avs_address + AW'(1);
                end
            end
        end
    end

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < int'(DW / 32); i++) w[32*i +: 32] = $urandom;
        return w;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!avs_waitrequest) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: waitrequest still %0b after 64 cycles, required 0", avs_waitrequest);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cmd_read(input logic [AW-1:0] a, input int unsigned bc);
        avs_address    = a;
        avs_burstcount = BW'(bc);
        avs_read       = 1'b1;
        wait_accept();
        avs_read = 1'b0;
    endtask

    // Beat i carries d+i (or random data/enables when rnd); gap_mask[i] idles one cycle after beat i.
    task automatic cmd_write(input logic [AW-1:0] a, input int unsigned bc, input logic [DW-1:0] d,
                             input logic [NB-1:0] be, input bit rnd, input logic [15:0] gap_mask);
        int unsigned n = (bc == 0) ? 1 : bc;
        avs_address    = a;
        avs_burstcount = BW'(bc);
        for (int unsigned i = 0; i < n; i++) begin
            avs_writedata  = rnd ? rand_word() : d + DW'(i);
            avs_byteenable = rnd ? NB'({$urandom, $urandom}) : be;
            avs_write      = 1'b1;
            wait_accept();
            avs_write = 1'b0;
            if (gap_mask[i] && i + 1 < n) step(1);
        end
    endtask

    initial begin
        logic [DW-1:0] w, w0;
        int unsigned   v0;
        step(3);
        reset = 1'b1;
        step(1);

        for (int a = 0; a < int'(DEPTH); a++) cmd_write(AW'(a), 1, '0, '1, 1'b1, '0);
        step(3);

        // Single write then single read of 0xA5 pattern.
        w = {NB{8'hA5}};
        cmd_write(AW'(5), 1, w, '1, 1'b0, '0);
        got_q.delete();
        v0 = vcount;
        cmd_read(AW'(5), 1);
        step(RL + 3);
        check("a5_pulses", DW'(vcount - v0), DW'(1));
        check("a5_data", got_q.size() > 0 ? got_q[0] : '0, {NB{8'hA5}});

        // Four-beat read burst returns words 8..11 back to back.
        got_q.delete();
        v0 = vcount;
        cmd_read(AW'(8), 4);
        step(RL + 5);
        check("burst4_pulses", DW'(vcount - v0), DW'(4));
        for (int i = 0; i < 4; i++)
            check("burst4_data", got_q.size() > i ? got_q[i] : '0, mdl_mem[8 + i]);

        // Byte-enable merge.
        cmd_write(AW'(3), 1, {NB{8'hFF}}, '1, 1'b0, '0);
        cmd_write(AW'(3), 1, '0, NB'(1), 1'b0, '0);
        got_q.delete();
        cmd_read(AW'(3), 1);
        step(RL + 2);
        w = {{(NB-1){8'hFF}}, 8'h00};
        check("be_model", mdl_mem[3], w);
        check("be_data", got_q.size() > 0 ? got_q[0] : '0, w);

        // Wrapping write burst with a gap, read back across the wrap.
        w0 = rand_word();
        cmd_write(AW'(DEPTH - 1), 3, w0, '1, 1'b0, 16'h0001);
        got_q.delete();
        cmd_read(AW'(DEPTH - 1), 3);
        step(RL + 4);
        check("wrap_model0", mdl_mem[0], w0 + DW'(1));
        check("wrap_beat0", got_q.size() > 0 ? got_q[0] : '0, w0);
        check("wrap_beat1", got_q.size() > 1 ? got_q[1] : '0, w0 + DW'(1));
        check("wrap_beat2", got_q.size() > 2 ? got_q[2] : '0, w0 + DW'(2));

        // Reset after the fourth beat of an 8-beat read burst.
        cmd_read(AW'(8), 8);
        step(3);
        reset = 1'b0;
        v0 = vcount;
        step(3);
        reset = 1'b1;
        step(6);
        check("reset_no_valid", DW'(vcount - v0), DW'(0));
        got_q.delete();
        cmd_read(AW'(5), 1);
        step(RL + 2);
        check("ram_after_reset", got_q.size() > 0 ? got_q[0] : '0, {NB{8'hA5}});

        // Read immediately after write, then simultaneous read+write.
        w = rand_word();
        cmd_write(AW'(7), 1, w, '1, 1'b0, '0);
        got_q.delete();
        cmd_read(AW'(7), 1);
        step(RL + 2);
        check("raw_data", got_q.size() > 0 ? got_q[0] : '0, w);
        w = rand_word();
        v0 = vcount;
        avs_address = AW'(7); avs_burstcount = BW'(1);
        avs_writedata = w; avs_byteenable = '1;
        avs_read = 1'b1; avs_write = 1'b1;
        wait_accept();
        avs_read = 1'b0; avs_write = 1'b0;
        step(RL + 2);
        check("rw_read_dropped", DW'(vcount - v0), DW'(0));
        check("rw_write_model", mdl_mem[7], w);
        got_q.delete();
        cmd_read(AW'(7), 1);
        step(RL + 2);
        check("rw_write_data", got_q.size() > 0 ? got_q[0] : '0, w);

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(1, 0) == 1)
                cmd_read(AW'($urandom), $urandom_range(15, 0));
            else
                cmd_write(AW'($urandom), $urandom_range(15, 0), '0, '0, 1'b1,
                          16'($urandom & $urandom));
            if ($urandom_range(3, 0) == 0) step($urandom_range(3, 1));
        end
        step(30);
        check("drain_pending", DW'(exp_q.size()), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
